// File: rtl/ml_pkg.sv
// rtl/ml_pkg.sv - shared widths, defaults and FSM state type for the perceptron training path
package ml_pkg;

  localparam int DEF_N_WEIGHTS = 4;
  localparam int DEF_W_W       = 12;
  localparam int DEF_X_W       = 8;
  localparam int DEF_LR_SHIFT  = 6;
  localparam int TGT_W         = 4;
  localparam int PRED_W        = 23;
  localparam int ERR_W         = PRED_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ERR  = 2'd1,
    S_UPD  = 2'd2,
    S_DONE = 2'd3
  } wu_state_t;

endpackage

// File: rtl/weight_update_if.sv
// rtl/weight_update_if.sv - start/done handshake, direct weight load and weight bank bus
interface weight_update_if
  import ml_pkg::*;
#(
  parameter int N_WEIGHTS = DEF_N_WEIGHTS,
  parameter int W_W       = DEF_W_W,
  parameter int X_W       = DEF_X_W
);
  localparam int IDX_W = (N_WEIGHTS > 1) ? $clog2(N_WEIGHTS) : 1;

  logic                       start_i;
  logic [TGT_W-1:0]           target_i;
  logic [PRED_W-1:0]          predicted_i;
  logic [N_WEIGHTS*X_W-1:0]   act_i;
  logic                       load_i;
  logic [IDX_W-1:0]           load_idx_i;
  logic [W_W-1:0]             load_data_i;
  logic                       ready_o;
  logic                       done_o;
  logic [N_WEIGHTS*W_W-1:0]   weights_o;

  modport master (
    output start_i, target_i, predicted_i, act_i,
    output load_i, load_idx_i, load_data_i,
    input  ready_o, done_o, weights_o
  );

  modport slave (
    input  start_i, target_i, predicted_i, act_i,
    input  load_i, load_idx_i, load_data_i,
    output ready_o, done_o, weights_o
  );

endinterface

// File: rtl/sat_sub.sv
// rtl/sat_sub.sv - wide signed a - b clamped to a W_W-bit signed result
module sat_sub #(
  parameter int A_W = 33,
  parameter int W_W = 12
) (
  input  logic signed [A_W-1:0] a,
  input  logic signed [A_W-1:0] b,
  output logic signed [W_W-1:0] y
);
  // One extra bit so the subtraction itself can never wrap.
  localparam logic signed [A_W:0] MAX_V = {{(A_W-W_W+2){1'b0}}, {(W_W-1){1'b1}}};
  localparam logic signed [A_W:0] MIN_V = {{(A_W-W_W+2){1'b1}}, {(W_W-1){1'b0}}};

  logic signed [A_W:0] diff;

  always_comb begin
    diff = {a[A_W-1], a} - {b[A_W-1], b};
    if (diff > MAX_V) begin
      y = MAX_V[W_W-1:0];
    end else if (diff < MIN_V) begin
      y = MIN_V[W_W-1:0];
    end else begin
      y = diff[W_W-1:0];
    end
  end

endmodule

// File: rtl/weight_update.sv
// rtl/weight_update.sv - sequential SGD step on a bank of signed weights, one weight per cycle
module weight_update
  import ml_pkg::*;
#(
  parameter int N_WEIGHTS = DEF_N_WEIGHTS,
  parameter int W_W       = DEF_W_W,
  parameter int X_W       = DEF_X_W,
  parameter int LR_SHIFT  = DEF_LR_SHIFT
) (
  input  logic           clk_i,
  input  logic           rst_i,
  weight_update_if.slave bus
);
  localparam int IDX_W  = (N_WEIGHTS > 1) ? $clog2(N_WEIGHTS) : 1;
  localparam int PROD_W = ERR_W + X_W + 1;

  wu_state_t                state_q;
  wu_state_t                state_d;
  logic [PRED_W-1:0]        pred_q;
  logic [TGT_W-1:0]         tgt_q;
  logic [N_WEIGHTS*X_W-1:0] act_q;
  logic signed [ERR_W-1:0]  err_q;
  logic [IDX_W-1:0]         idx_q;
  logic signed [W_W-1:0]    w_q [N_WEIGHTS];

  logic                     accept;
  logic                     last_idx;
  logic signed [ERR_W-1:0]  err_d;
  logic [X_W-1:0]           x_sel;
  logic signed [PROD_W-1:0] err_ext;
  logic signed [PROD_W-1:0] x_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] delta;
  logic signed [PROD_W-1:0] w_ext;
  logic signed [W_W-1:0]    w_new;

  assign accept   = (state_q == S_IDLE) && bus.start_i;
  assign last_idx = (idx_q == IDX_W'(N_WEIGHTS - 1));
  assign err_d    = $signed({1'b0, pred_q}) - $signed({{(ERR_W-TGT_W){1'b0}}, tgt_q});

  // Single shared multiplier; the gradient's factor of 2 is folded into the shift.
  assign x_sel   = act_q[idx_q*X_W +: X_W];
  assign err_ext = PROD_W'(err_q);
  assign x_ext   = $signed({{(PROD_W-X_W){1'b0}}, x_sel});
  assign prod    = err_ext * x_ext;
  assign delta   = prod >>> (LR_SHIFT - 1);
  assign w_ext   = PROD_W'(w_q[idx_q]);

  sat_sub #(
    .A_W (PROD_W),
    .W_W (W_W)
  ) u_sat_sub (
    .a (w_ext),
    .b (delta),
    .y (w_new)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start_i) state_d = S_ERR;
      S_ERR:   state_d = S_UPD;
      S_UPD:   if (last_idx) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ready_o   = (state_q == S_IDLE);
    bus.done_o    = (state_q == S_DONE);
    bus.weights_o = '0;
    for (int k = 0; k < N_WEIGHTS; k++) begin
      bus.weights_o[k*W_W +: W_W] = w_q[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pred_q <= '0;
      tgt_q  <= '0;
      act_q  <= '0;
      err_q  <= '0;
      idx_q  <= '0;
      for (int k = 0; k < N_WEIGHTS; k++) begin
        w_q[k] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          // A start in the same cycle as a load takes priority; the load is dropped.
          if (accept) begin
            pred_q <= bus.predicted_i;
            tgt_q  <= bus.target_i;
            act_q  <= bus.act_i;
          end else if (bus.load_i && (int'(bus.load_idx_i) < N_WEIGHTS)) begin
            w_q[bus.load_idx_i] <= bus.load_data_i;
          end
        end
        S_ERR: begin
          err_q <= err_d;
          idx_q <= '0;
        end
        S_UPD: begin
          w_q[idx_q] <= w_new;
          idx_q      <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_update.sv
// tb/tb_weight_update.sv - directed bench with a timeline/arithmetic model of the SGD step
module tb_weight_update;
  import ml_pkg::*;

  localparam int N  = 4;
  localparam int WW = 12;
  localparam int XW = 8;
  localparam int LR = 6;
  localparam int IW = $clog2(N);
  localparam longint WMAX = (64'sd1 <<< (WW - 1)) - 1;
  localparam longint WMIN = -(64'sd1 <<< (WW - 1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  weight_update_if #(.N_WEIGHTS(N), .W_W(WW), .X_W(XW)) bus ();

  weight_update #(.N_WEIGHTS(N), .W_W(WW), .X_W(XW), .LR_SHIFT(LR)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int     checks   = 0;
  int     failures = 0;
  int     phase    = 0;
  int     done_cnt = 0;
  bit     chk_en   = 1'b0;
  longint mw [N];
  longint nw [N];

  function automatic longint floor_div(longint p, longint d);
    longint q;
    q = p / d;
    if ((p % d != 0) && (p < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint clampw(longint v);
    if (v > WMAX) return WMAX;
    if (v < WMIN) return WMIN;
    return v;
  endfunction

  function automatic longint wt(int k);
    logic signed [WW-1:0] g;
    g = bus.weights_o[k*WW +: WW];
    return longint'(g);
  endfunction

  // phase counts cycles since accept: 0 idle, weight k lands at the edge ending phase k+2.
  always @(posedge clk) begin : model
    longint e;
    longint x;
    if (rst) begin
      phase = 0;
      for (int k = 0; k < N; k++) mw[k] = 0;
    end else if (phase == 0) begin
      if (bus.start_i) begin
        e = longint'(bus.predicted_i) - longint'(bus.target_i);
        for (int k = 0; k < N; k++) begin
          x = longint'(bus.act_i[k*XW +: XW]);
          nw[k] = clampw(mw[k] - floor_div(2 * e * x, 64'sd1 <<< LR));
        end
        phase = 1;
      end else if (bus.load_i) begin
        mw[bus.load_idx_i] = longint'($signed(bus.load_data_i));
      end
    end else begin
      if (phase >= 2 && phase <= N + 1) mw[phase-2] = nw[phase-2];
      phase = (phase == N + 2) ? 0 : phase + 1;
    end
  end

  always @(negedge clk) begin : compare
    logic signed [WW-1:0] g;
    if (chk_en) begin
      if (bus.done_o === 1'b1) done_cnt++;
      checks++;
      if (bus.ready_o !== (phase == 0)) begin
        failures++;
        $display("FAIL ready t=%0t got=%b exp=%b", $time, bus.ready_o, (phase == 0));
      end
      checks++;
      if (bus.done_o !== (phase == N + 2)) begin
        failures++;
        $display("FAIL done t=%0t got=%b exp=%b", $time, bus.done_o, (phase == N + 2));
      end
      for (int k = 0; k < N; k++) begin
        g = bus.weights_o[k*WW +: WW];
        checks++;
        if (g !== WW'(mw[k])) begin
          failures++;
          $display("FAIL weight%0d t=%0t got=%0d exp=%0d", k, $time, g, mw[k]);
        end
      end
    end
  end

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*XW-1:0] rep(int v);
    logic [N*XW-1:0] r;
    for (int k = 0; k < N; k++) r[k*XW +: XW] = XW'(v);
    return r;
  endfunction

  task automatic load_w(input int idx, input int val);
    bus.load_i      = 1'b1;
    bus.load_idx_i  = IW'(idx);
    bus.load_data_i = WW'(val);
    step();
    bus.load_i = 1'b0;
  endtask

  task automatic load_all(input int val);
    for (int k = 0; k < N; k++) load_w(k, val);
  endtask

  task automatic scramble();
    bus.predicted_i = 23'($urandom);
    bus.target_i    = 4'($urandom);
    bus.act_i       = (N*XW)'({$urandom(), $urandom()});
  endtask

  task automatic wait_done(input int first, output int lat);
    lat = first;
    while (bus.done_o !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    if (lat >= 40) chk("done_timeout", lat, 6);
    step();
  endtask

  task automatic run(input int pred, input int tgt, input logic [N*XW-1:0] act, output int lat);
    bus.predicted_i = 23'(pred);
    bus.target_i    = 4'(tgt);
    bus.act_i       = act;
    bus.start_i     = 1'b1;
    step();
    bus.start_i = 1'b0;
    scramble();
    wait_done(1, lat);
  endtask

  initial begin
    int lat;
    int dc;
    logic [N*XW-1:0] a;
    bus.start_i = 1'b0;
    bus.load_i = 1'b0;
    bus.load_idx_i = '0;
    bus.load_data_i = '0;
    bus.predicted_i = '0;
    bus.target_i = '0;
    bus.act_i = '0;
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_ready", longint'(bus.ready_o), 1);
    chk("rst_done", longint'(bus.done_o), 0);
    chk("rst_weights", longint'(bus.weights_o), 0);

    load_all(100);
    run(5, 3, rep(16), lat);
    chk("basic_latency", lat, 6);
    for (int k = 0; k < N; k++) chk("basic_w", wt(k), 99);

    run(3, 3, rep(200), lat);
    chk("zero_err_latency", lat, 6);
    chk("zero_err_w0", wt(0), 99);

    load_all(100);
    a = rep(64);
    a[XW +: XW] = 8'd1;
    run(0, 15, a, lat);
    chk("neg_w0", wt(0), 130);
    chk("floor_w1", wt(1), 101);

    load_w(0, 2000);
    a = '0;
    a[0 +: XW] = 8'd255;
    run(0, 15, a, lat);
    chk("sat_hi_w0", wt(0), 2047);
    load_w(0, 0);
    a[0 +: XW] = 8'd1;
    run(8000000, 0, a, lat);
    chk("sat_lo_w0", wt(0), -2048);

    load_all(100);
    dc = done_cnt;
    bus.predicted_i = 23'd5;
    bus.target_i = 4'd3;
    bus.act_i = rep(16);
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    step();
    bus.start_i = 1'b1;
    bus.load_i = 1'b1;
    bus.load_idx_i = IW'(2);
    bus.load_data_i = WW'(7);
    step();
    bus.start_i = 1'b0;
    bus.load_i = 1'b0;
    wait_done(3, lat);
    repeat (3) step();
    chk("ignored_done_count", done_cnt - dc, 1);
    chk("ignored_w2", wt(2), 99);

    load_all(50);
    bus.load_i = 1'b1;
    bus.load_idx_i = IW'(1);
    bus.load_data_i = WW'(7);
    bus.predicted_i = 23'd5;
    bus.target_i = 4'd3;
    bus.act_i = rep(16);
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    bus.load_i = 1'b0;
    wait_done(1, lat);
    chk("same_cycle_w1", wt(1), 49);

    dc = done_cnt;
    bus.predicted_i = 23'd5;
    bus.target_i = 4'd3;
    bus.act_i = rep(16);
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_weights", longint'(bus.weights_o), 0);
    chk("midrst_ready", longint'(bus.ready_o), 1);
    repeat (10) step();
    chk("midrst_no_done", done_cnt - dc, 0);
    run(5, 3, rep(16), lat);
    chk("after_rst_latency", lat, 6);
    for (int k = 0; k < N; k++) chk("after_rst_w", wt(k), -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
